// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program RAM loader: count byte, data bytes, checksum, zero fill
module prog_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_req,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       prog_mode,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic       done,
    output logic [1:0] err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        FILL  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_CSUM  = 2'b10;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic [1:0] err_q, err_d;
    logic       prog_mode_q, prog_mode_d;
    logic       ram_we_q, ram_we_d;
    logic [3:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_wdata_q, ram_wdata_d;
    logic       done_q, done_d;

    logic       accept;
    logic [7:0] csum_chk;
    logic [4:0] idx_inc;

    assign byte_ready = (state_q == COUNT) || (state_q == DATA) || (state_q == CSUM);
    assign accept     = byte_valid && byte_ready;
    assign csum_chk   = sum_q + byte_in;
    assign idx_inc    = idx_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        err_d       = err_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE, ERROR: begin
                if (load_req) begin
                    state_d = COUNT;
                    err_d   = ERR_NONE;
                    sum_d   = 8'h00;
                    idx_d   = 5'd0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if (byte_in == 8'd0 || byte_in > 8'd16) begin
                        state_d = ERROR;
                        err_d   = ERR_COUNT;
                    end else begin
                        cnt_d   = byte_in[4:0];
                        sum_d   = byte_in;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[3:0];
                    ram_wdata_d = byte_in;
                    sum_d       = csum_chk;
                    idx_d       = idx_inc;
                    if (idx_inc == cnt_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (csum_chk != 8'h00) begin
                        state_d = ERROR;
                        err_d   = ERR_CSUM;
                    end else if (idx_q[4]) begin
                        // a full 16-word image leaves nothing to zero fill
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // index is 5 bits so running past address 15 is seen as bit 4, never as a wrap
                if (idx_q[4]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q[3:0];
                    ram_wdata_d = 8'h00;
                    idx_d       = idx_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        prog_mode_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            idx_q       <= 5'd0;
            sum_q       <= 8'h00;
            err_q       <= ERR_NONE;
            prog_mode_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 4'd0;
            ram_wdata_q <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            prog_mode_q <= prog_mode_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            done_q      <= done_d;
        end
    end

    assign prog_mode = prog_mode_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized bench for prog_loader against a load-outcome model
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_req = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       prog_mode;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic       done;
    logic [1:0] err;

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .prog_mode  (prog_mode),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // write/done monitor, sampled on the falling edge
    int         wcount = 0;
    logic [3:0] w_addr [32];
    logic [7:0] w_data [32];
    int         done_cnt = 0;
    logic       pm_prev = 1'b0;
    logic       done_pm_now = 1'b0;
    logic       done_pm_prev = 1'b0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (wcount < 32) begin
                w_addr[wcount] = ram_addr;
                w_data[wcount] = ram_wdata;
            end
            wcount++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_pm_now  = prog_mode;
            done_pm_prev = pm_prev;
        end
        pm_prev = prog_mode;
    end

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic busy);
        int  n;
        bit  ok;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        if (busy) load_req = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            check("handshake_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic make_load(input int n, input bit good, output logic [7:0] q[$]);
        int s;
        int c;
        q = {};
        q.push_back(8'(n));
        if (n >= 1 && n <= 16) begin
            s = n;
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                s += int'(q[i+1]);
            end
            c = (256 - (s % 256)) % 256;
            if (!good) c = (c + int'($urandom_range(1, 255))) % 256;
            q.push_back(8'(c));
        end
    endtask

    task automatic run_load(input logic [7:0] q[$], input int busy_idx, input string tag);
        int         n;
        int         s;
        int         exp_err;
        int         exp_w;
        int         exp_done;
        logic [7:0] exp_mem [16];
        int         t;

        // outcome model: what the RAM and status should look like for this byte stream
        n = int'(q[0]);
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        if (n == 0 || n > 16) begin
            exp_err = 1; exp_w = 0; exp_done = 0;
        end else begin
            s = n;
            for (int i = 1; i <= n; i++) begin
                s += int'(q[i]);
                exp_mem[i-1] = q[i];
            end
            s = (s + int'(q[n+1])) % 256;
            if (s != 0) begin
                exp_err = 2; exp_w = n; exp_done = 0;
            end else begin
                exp_err = 0; exp_w = 16; exp_done = 1;
            end
        end

        wcount   = 0;
        done_cnt = 0;
        pulse_load();
        check({tag, "_pm_rise"}, 32'(prog_mode), 32'd1);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        for (int i = 0; i < q.size(); i++)
            send_byte(q[i], int'($urandom_range(0, 2)), (i == busy_idx));

        if (exp_done == 1) begin
            t = 0;
            while (done_cnt == 0 && t < 60) begin
                @(posedge clk); #1;
                t++;
            end
            check({tag, "_done_wait"}, 32'(done_cnt > 0), 32'd1);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end

        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_wcount"}, 32'(wcount), 32'(exp_w));
        for (int i = 0; i < exp_w && i < 32; i++) begin
            check({tag, "_waddr"}, 32'(w_addr[i]), 32'(i));
            check({tag, "_wdata"}, 32'(w_data[i]), 32'(exp_mem[i]));
        end
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_pm_end"}, 32'(prog_mode), 32'(exp_done == 0));
        check({tag, "_ready_end"}, 32'(byte_ready), 32'd0);
        if (exp_done == 1) begin
            check({tag, "_pm_at_done"}, 32'(done_pm_now), 32'd0);
            check({tag, "_pm_before_done"}, 32'(done_pm_prev), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        int         saved;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_prog_mode", 32'(prog_mode), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("idle_hold_pm", 32'(prog_mode), 32'd0);

        q = {8'h02, 8'h51, 8'hE0, 8'hCD};
        run_load(q, -1, "good");

        q = {8'h02, 8'h51, 8'hE0, 8'hCE};
        run_load(q, -1, "badcsum");
        saved      = wcount;
        byte_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check("err_ignore_valid_w", 32'(wcount), 32'(saved));
        check("err_ignore_valid_e", 32'(err), 32'd2);
        make_load(int'($urandom_range(1, 15)), 1'b1, q);
        run_load(q, -1, "recover");

        q = {8'h00};
        run_load(q, -1, "cnt00");
        q = {8'h11};
        run_load(q, -1, "cnt11");

        make_load(16, 1'b1, q);
        run_load(q, -1, "full");

        make_load(6, 1'b1, q);
        run_load(q, 3, "busy");

        for (int k = 0; k < 20; k++) begin
            make_load(int'($urandom_range(0, 18)), ($urandom_range(0, 3) != 0), q);
            run_load(q, int'($urandom_range(0, 8)), "rand");
        end

        wcount = 0;
        pulse_load();
        send_byte(8'h04, 0, 1'b0);
        send_byte(8'h3C, 1, 1'b0);
        send_byte(8'hA5, 0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("stall_wcount", 32'(wcount), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_prog_mode", 32'(prog_mode), 32'd0);
        check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_ram_we", 32'(ram_we), 32'd0);
        check("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
        check("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        check("post_rst_wcount", 32'(wcount), 32'd2);
        check("post_rst_pm", 32'(prog_mode), 32'd0);
        check("post_rst_ready", 32'(byte_ready), 32'd0);

        make_load(3, 1'b1, q);
        run_load(q, -1, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: load_req  input  1  start a program load; sampled on rising edge.
REQ-004 SHALL have port: byte_in  input  8  host byte stream data.
REQ-005 SHALL have port: byte_valid  input  1  byte_in holds a valid byte.
REQ-006 SHALL have port: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-007 SHALL have port: prog_mode  output  1  holds the instruction decoder off while loading.
REQ-008 SHALL have port: ram_addr  output  4  program RAM write address.
REQ-009 SHALL have port: ram_wdata  output  8  program RAM write data.
REQ-010 SHALL have port: ram_we  output  1  program RAM write strobe, one word per cycle.
REQ-011 SHALL have port: done  output  1  one-cycle pulse on successful load completion.
REQ-012 SHALL have port: err  output  2  sticky error code: 00 none, 01 bad count, 10 checksum mismatch.

Function
REQ-013 SHALL implement states IDLE, COUNT, DATA, CSUM, FILL, ERROR.
REQ-014 SHALL transfer a byte only on a rising edge with byte_valid=1 and byte_ready=1.
REQ-015 SHALL drive byte_ready=1 only in COUNT, DATA and CSUM; 0 elsewhere.
REQ-016 SHALL drive prog_mode=1 in every state except IDLE; registered, so it rises the cycle after load_req is sampled.
REQ-017 IDLE: load_req=1 -> COUNT, clear err to 00, clear running sum and write index.
REQ-018 COUNT: accepted byte N in 1..16 -> store N, sum=N, -> DATA; N=0 or N>16 -> ERROR with err=01.
REQ-019 DATA: each accepted byte SHALL be written to address index (0 upward), added to sum modulo 256, index incremented; after the N-th byte -> CSUM.
REQ-020 Writes SHALL be registered: byte accepted at edge k gives ram_we=1, ram_addr, ram_wdata valid during cycle k+1; ram_we=0 on every cycle without a write.
REQ-021 CSUM: accepted byte C; (sum + C) mod 256 = 0x00 -> FILL; otherwise -> ERROR with err=10; no RAM write for C.
REQ-022 FILL: SHALL write 0x00 to addresses N..15, one per cycle, no handshake; N=16 gives zero fill writes.
REQ-023 After the last fill write (or immediately if N=16), SHALL return to IDLE and pulse done=1 for exactly one cycle, coinciding with prog_mode falling to 0.
REQ-024 ERROR: prog_mode stays 1, err held; load_req=1 -> COUNT with err cleared; byte_valid ignored.
REQ-025 load_req SHALL be ignored in COUNT, DATA, CSUM and FILL.
REQ-026 Write index SHALL be 5 bits internally, so address 15 followed by completion never wraps to address 0.
REQ-027 byte_valid deasserted mid-stream SHALL stall the current state indefinitely with no timeout and no writes.

Reset
REQ-028 rst=0 SHALL asynchronously force state IDLE, prog_mode=0, byte_ready=0, ram_we=0, ram_addr=0, ram_wdata=0x00, done=0, err=00, sum=0, index=0.
REQ-029 Reset asserted mid-load SHALL abort with no further RAM writes; partially loaded RAM contents are not restored.
REQ-030 After reset release, the block SHALL remain in IDLE until load_req=1 is sampled.

Verification
REQ-031 Good load: load_req, then bytes 0x02, 0x51, 0xE0, 0xCD -> writes [0]=0x51, [1]=0xE0, [2..15]=0x00; done pulses once; prog_mode 1->0 on the done cycle; err=00.
REQ-032 Bad checksum: 0x02, 0x51, 0xE0, 0xCE -> no fill writes, err=10, prog_mode stays 1; a new load_req recovers and a good load completes.
REQ-033 Bad count: count bytes 0x00 and 0x11 (separate runs) -> err=01 after the count byte, zero RAM writes.
REQ-034 Full load: N=0x10 with 16 data bytes and a correct checksum -> 16 writes to addresses 0..15, no fill, done pulses, no address wrap.
REQ-035 Stall and reset: byte_valid gaps mid-DATA -> no spurious ram_we; rst=0 asserted mid-DATA -> all outputs go to their reset values immediately.
REQ-036 Busy request: load_req=1 during DATA -> ignored, load completes normally.
